// File: rtl/uart_tx_word_buffer_if.sv
// Word push channel from the UART pipeline interface into the TX word buffer.
// The producer drives a word with a 1-cycle start strobe and watches the
// buffer's room flag before each send.
interface uart_tx_word_buffer_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] word;             // word to transmit
    logic                  tx_start;         // 1-cycle push strobe
    logic                  tx_buffer_empty;  // buffer has room for more words

    modport master (
        output word,
        output tx_start,
        input  tx_buffer_empty
    );

    modport slave (
        input  word,
        input  tx_start,
        output tx_buffer_empty
    );
endinterface

// File: rtl/uart_tx_word_buffer.sv
// TX word buffer: queues words from the pipeline interface in a small FIFO
// and serialises each one MSB-byte-first into the byte-wide UART TX core
// using a start-strobe / done-tick handshake.
module uart_tx_word_buffer #(
    parameter int DATA_WIDTH     = 32,  // multiple of BYTE_WIDTH
    parameter int BYTE_WIDTH     = 8,
    parameter int FIFO_ADDR_BITS = 2    // depth = 2**FIFO_ADDR_BITS, at least 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    uart_tx_word_buffer_if.slave  push_if,
    input  logic                  i_byte_done,
    output logic [BYTE_WIDTH-1:0] o_byte,
    output logic                  o_byte_start,
    output logic                  o_busy,
    output logic                  o_overflow
);

    localparam int DEPTH = 1 << FIFO_ADDR_BITS;
    localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
    localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;

    localparam logic [FIFO_ADDR_BITS:0] DEPTH_C   = (FIFO_ADDR_BITS + 1)'(DEPTH);
    // Room threshold leaves two free slots: the producer samples the flag a
    // cycle ahead of its registered strobe and may land one extra push.
    localparam logic [FIFO_ADDR_BITS:0] ROOM_C    = (FIFO_ADDR_BITS + 1)'(DEPTH - 2);
    localparam logic [IDX_W-1:0]        LAST_IDX  = IDX_W'(NB - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT
    } state_t;

    state_t state, state_nxt;

    logic [DATA_WIDTH-1:0]     mem [DEPTH];
    logic [FIFO_ADDR_BITS-1:0] wr_ptr, rd_ptr;
    logic [FIFO_ADDR_BITS:0]   count;

    logic [DATA_WIDTH-1:0]     shreg;
    logic [IDX_W-1:0]          byte_idx;

    logic fifo_full, fifo_nempty;
    logic push, pop, drop;
    logic load_word, emit_byte, advance;

    // ---------------- FIFO bookkeeping ----------------
    assign fifo_full   = (count == DEPTH_C);
    assign fifo_nempty = (count != '0);

    // The head word is popped straight into the shift register from IDLE.
    assign pop  = load_word;
    // A pop in the same cycle frees a slot, so a push against a full FIFO is
    // still accepted when the serialiser is taking the head.
    assign push = push_if.tx_start && (!fifo_full || pop);
    assign drop = push_if.tx_start && fifo_full && !pop;

    assign push_if.tx_buffer_empty = (count <= ROOM_C);
    assign o_busy                  = fifo_nempty || (state != S_IDLE);

    // Word storage; contents are don't-care until written, so no reset.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr] <= push_if.word;
        end
    end

    // Pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            o_overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop) begin
                o_overflow <= 1'b1;
            end
        end
    end

    // ---------------- Serialiser FSM ----------------
    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and datapath control; done ticks only matter in WAIT.
    always_comb begin
        state_nxt = state;
        load_word = 1'b0;
        emit_byte = 1'b0;
        advance   = 1'b0;
        case (state)
            S_IDLE: begin
                if (fifo_nempty) begin
                    load_word = 1'b1;
                    state_nxt = S_START;
                end
            end
            S_START: begin
                emit_byte = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (i_byte_done) begin
                    if (byte_idx == LAST_IDX) begin
                        state_nxt = S_IDLE;
                    end else begin
                        advance   = 1'b1;
                        state_nxt = S_START;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Shift register, byte index and the registered byte/strobe to the core.
    // o_byte is only updated in START so it holds steady while the core
    // shifts the byte out.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            shreg        <= '0;
            byte_idx     <= '0;
            o_byte       <= '0;
            o_byte_start <= 1'b0;
        end else begin
            o_byte_start <= emit_byte;
            if (load_word) begin
                shreg    <= mem[rd_ptr];
                byte_idx <= '0;
            end else if (advance) begin
                shreg    <= shreg << BYTE_WIDTH;
                byte_idx <= byte_idx + 1'b1;
            end
            if (emit_byte) begin
                o_byte <= shreg[DATA_WIDTH-1 -: BYTE_WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_word_buffer.sv
// Bench for uart_tx_word_buffer: a table of single-word transfers plus
// directed sequences for latency, back-pressure, overflow, full-FIFO
// push-with-pop and mid-word reset. A small TX-core responder answers each
// byte start with a done tick after a programmable delay.
module tb_uart_tx_word_buffer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       resp_done = 1'b0;
    logic       man_done = 1'b0;
    logic       byte_done;
    logic [7:0] o_byte;
    logic       o_byte_start, o_busy, o_overflow;

    uart_tx_word_buffer_if #(.DATA_WIDTH(32)) bus ();

    assign byte_done = resp_done | man_done;

    uart_tx_word_buffer #(
        .DATA_WIDTH    (32),
        .BYTE_WIDTH    (8),
        .FIFO_ADDR_BITS(2)
    ) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .push_if     (bus),
        .i_byte_done (byte_done),
        .o_byte      (o_byte),
        .o_byte_start(o_byte_start),
        .o_busy      (o_busy),
        .o_overflow  (o_overflow)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- TX core responder ----------------
    logic [7:0] got[$];
    int         n_starts = 0;
    bit         core_en = 1'b1;
    int         dly = 10;
    int         since_done = -1;
    int         bidx = 0;
    logic       pending = 1'b0;
    int         wcnt = 0;
    logic [7:0] cur = 8'h00;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            resp_done = 1'b0;
            if (since_done >= 0) since_done++;
            if (rst) begin
                pending    = 1'b0;
                bidx       = 0;
                since_done = -1;
            end else if (o_byte_start) begin
                // within a word the next start follows a done by one cycle
                if (bidx != 0 && since_done >= 0) chk("byte_gap", since_done, 2);
                got.push_back(o_byte);
                cur        = o_byte;
                n_starts++;
                pending    = 1'b1;
                wcnt       = 0;
                since_done = -1;
                bidx       = (bidx + 1) % 4;
            end else if (man_done) begin
                pending    = 1'b0;
                since_done = -1;
            end else if (pending && core_en) begin
                wcnt++;
                if (wcnt >= dly) begin
                    chk("byte_hold", o_byte, cur);
                    resp_done  = 1'b1;
                    pending    = 1'b0;
                    since_done = 0;
                end
            end
        end
    end

    // Wait at negedges until n bytes collected (and optionally idle).
    task automatic wait_bytes(input int n, input bit need_idle, input int budget, output bit emp_ok);
        emp_ok = 1'b1;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (!bus.tx_buffer_empty) emp_ok = 1'b0;
            if (got.size() >= n && (!need_idle || !o_busy)) return;
        end
        checks++;
        errors++;
        $display("FAIL timeout: got %0d bytes busy=%0b, required %0d bytes", got.size(), o_busy, n);
    endtask

    typedef struct {
        logic [31:0] word;
        logic [7:0]  exp [4];
    } vec_t;

    vec_t vecs [4];

    initial begin
        int  b0;
        int  s0;
        bit  eok;
        logic [7:0] eb;

        vecs[0].word = 32'h636F6E74; vecs[0].exp = '{8'h63, 8'h6F, 8'h6E, 8'h74};
        vecs[1].word = 32'hFFFFFFFF; vecs[1].exp = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
        vecs[2].word = 32'h00000080; vecs[2].exp = '{8'h00, 8'h00, 8'h00, 8'h80};
        vecs[3].word = 32'hA5C30F5A; vecs[3].exp = '{8'hA5, 8'hC3, 8'h0F, 8'h5A};

        bus.word     = 32'h0;
        bus.tx_start = 1'b0;

        // ---- reset state ----
        repeat (3) @(negedge clk);
        chk("rst_byte", o_byte, 8'h00);
        chk("rst_start", o_byte_start, 1'b0);
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_ovf", o_overflow, 1'b0);
        chk("rst_empty", bus.tx_buffer_empty, 1'b1);
        rst = 1'b0;
        @(negedge clk);

        // ---- first-byte latency: push N, pop N+1, start N+2 ----
        b0 = got.size();
        bus.word = 32'h11223344; bus.tx_start = 1'b1;
        @(negedge clk);
        bus.tx_start = 1'b0;
        chk("lat_n_start", o_byte_start, 1'b0);
        chk("lat_n_busy", o_busy, 1'b1);
        @(negedge clk);
        chk("lat_n1_start", o_byte_start, 1'b0);
        @(negedge clk);
        chk("lat_n2_start", o_byte_start, 1'b1);
        chk("lat_n2_byte", o_byte, 8'h11);
        wait_bytes(b0 + 4, 1'b1, 1000, eok);
        chk("lat_b3", got[b0+3], 8'h44);

        // ---- table: single words, MSB byte first ----
        for (int v = 0; v < 4; v++) begin
            b0 = got.size();
            s0 = n_starts;
            bus.word = vecs[v].word; bus.tx_start = 1'b1;
            @(negedge clk);
            bus.tx_start = 1'b0;
            wait_bytes(b0 + 4, 1'b1, 1000, eok);
            for (int i = 0; i < 4; i++) chk($sformatf("tbl%0d_b%0d", v, i), got[b0+i], vecs[v].exp[i]);
            chk($sformatf("tbl%0d_strobes", v), n_starts - s0, 4);
            chk($sformatf("tbl%0d_busy", v), o_busy, 1'b0);
            chk($sformatf("tbl%0d_empty_held", v), eok, 1'b1);
        end

        // ---- back-pressure: room flag drops at count 3 ----
        core_en = 1'b0;
        b0 = got.size();
        for (int w = 0; w < 4; w++) begin
            bus.word = 32'hA0A1A2A3 + 32'h10101010 * w; bus.tx_start = 1'b1;
            @(negedge clk);
            // count after pushes: 1, 1 (head popped), 2, 3
            chk($sformatf("bp_empty_%0d", w), bus.tx_buffer_empty, (w == 3) ? 1'b0 : 1'b1);
        end
        bus.tx_start = 1'b0;
        core_en = 1'b1;
        wait_bytes(b0 + 16, 1'b1, 2000, eok);
        for (int w = 0; w < 4; w++)
            for (int i = 0; i < 4; i++) begin
                eb = 8'hA0 + 8'h10 * w[7:0] + i[7:0];
                chk($sformatf("bp_w%0d_b%0d", w, i), got[b0+4*w+i], eb);
            end
        chk("bp_ovf", o_overflow, 1'b0);
        chk("bp_empty_end", bus.tx_buffer_empty, 1'b1);

        // ---- overflow: head in serialiser + 4 queued, 6th push dropped ----
        core_en = 1'b0;
        b0 = got.size();
        for (int w = 0; w < 6; w++) begin
            bus.word = 32'h01020304 + 32'h10101010 * w; bus.tx_start = 1'b1;
            @(negedge clk);
            chk($sformatf("ov_flag_%0d", w), o_overflow, (w == 5) ? 1'b1 : 1'b0);
        end
        bus.tx_start = 1'b0;
        chk("ov_empty_full", bus.tx_buffer_empty, 1'b0);
        core_en = 1'b1;
        wait_bytes(b0 + 20, 1'b1, 2000, eok);
        repeat (30) @(negedge clk);
        chk("ov_nbytes", got.size() - b0, 20);
        for (int w = 0; w < 5; w++)
            for (int i = 0; i < 4; i++) begin
                eb = 8'h01 + 8'h10 * w[7:0] + i[7:0];
                chk($sformatf("ov_w%0d_b%0d", w, i), got[b0+4*w+i], eb);
            end
        chk("ov_sticky", o_overflow, 1'b1);

        // ---- reset after the second byte of a word ----
        b0 = got.size();
        bus.word = 32'h5A5B5C5D; bus.tx_start = 1'b1;
        @(negedge clk);
        bus.tx_start = 1'b0;
        wait_bytes(b0 + 2, 1'b0, 1000, eok);
        rst = 1'b1;
        @(negedge clk);
        chk("mr_byte", o_byte, 8'h00);
        chk("mr_start", o_byte_start, 1'b0);
        chk("mr_busy", o_busy, 1'b0);
        chk("mr_ovf", o_overflow, 1'b0);
        chk("mr_empty", bus.tx_buffer_empty, 1'b1);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        chk("mr_no_more", got.size() - b0, 2);
        chk("mr_b1", got[b0+1], 8'h5B);

        // ---- full FIFO, push coincident with the IDLE pop ----
        core_en = 1'b0;
        b0 = got.size();
        for (int w = 0; w < 5; w++) begin
            bus.word = 32'h21222324 + 32'h10101010 * w; bus.tx_start = 1'b1;
            @(negedge clk);
        end
        bus.tx_start = 1'b0;
        chk("fp_full_empty", bus.tx_buffer_empty, 1'b0);
        // finish the in-flight word by hand
        for (int k = 0; k < 4; k++) begin
            man_done = 1'b1;
            @(negedge clk);
            man_done = 1'b0;
            if (k < 3) repeat (3) @(negedge clk);
        end
        // FSM is now IDLE with 4 words queued; this push meets the pop
        bus.word = 32'h71727374; bus.tx_start = 1'b1;
        @(negedge clk);
        bus.tx_start = 1'b0;
        chk("fp_empty", bus.tx_buffer_empty, 1'b0);
        chk("fp_ovf", o_overflow, 1'b0);
        chk("fp_busy", o_busy, 1'b1);
        core_en = 1'b1;
        wait_bytes(b0 + 24, 1'b1, 3000, eok);
        for (int w = 0; w < 6; w++)
            for (int i = 0; i < 4; i++) begin
                eb = 8'h21 + 8'h10 * w[7:0] + i[7:0];
                chk($sformatf("fp_w%0d_b%0d", w, i), got[b0+4*w+i], eb);
            end
        chk("fp_ovf_end", o_overflow, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
